// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand/result routing sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_OPERAND   = 2'd1,
    S_EXECUTE   = 2'd2,
    S_WRITEBACK = 2'd3
  } alu_seq_state_t;

  localparam logic [3:0] SRC_B_IMM = 4'd8;
  localparam int         NUM_REGS  = 8;
  localparam int         REG_IDX_W = $clog2(NUM_REGS);
  localparam int         IMM_W     = 8;
  localparam int         LAT_W     = 4;

  typedef struct packed {
    logic [REG_IDX_W-1:0] src_a;
    logic [3:0]           src_b;
    logic [IMM_W-1:0]     imm;
    logic [REG_IDX_W-1:0] dst;
    logic                 wb;
  } alu_op_t;

endpackage

// File: rtl/alu_latency_timer.sv
// Loadable down-counter that times the ALU latency; expired while the count is zero.
module alu_latency_timer
  import alu_seq_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_value,
  input  logic             i_dec,
  output logic             o_expired
);

  logic [LAT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - LAT_W'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/alu_datapath_sequencer.sv
// Sequences one micro-op through operand mux, ALU latency and result demux.
// Define ALU_SEQ_OVERLAP_EN to accept the next op during WRITEBACK.
module alu_datapath_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WORD_SIZE   = 8,
  parameter int ALU_LATENCY = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_op_valid,
  output logic                 o_op_ready,
  input  logic [2:0]           i_op_src_a,
  input  logic [3:0]           i_op_src_b,
  input  logic [WORD_SIZE-1:0] i_op_imm,
  input  logic [2:0]           i_op_dst,
  input  logic                 i_op_wb,
  output logic [2:0]           o_sel_a,
  output logic [3:0]           o_sel_b,
  output logic [WORD_SIZE-1:0] o_imm_out,
  output logic                 o_mux_en,
  output logic                 o_alu_start,
  output logic [2:0]           o_wb_sel,
  output logic                 o_wb_en,
  output logic                 o_done,
  output logic                 o_err_illegal,
  output logic [CNT_WIDTH-1:0] o_ops_completed
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LATENCY - 1);

  alu_seq_state_t       r_state;
  alu_op_t              r_op;
  logic                 r_mux_en;
  logic                 r_alu_start;
  logic [2:0]           r_wb_sel;
  logic                 r_wb_en;
  logic                 r_done;
  logic                 r_err_illegal;
  logic [CNT_WIDTH-1:0] r_ops_completed;

  logic w_ready;
  logic w_accept;
  logic w_launch;
  logic w_drop;
  logic w_timer_load;
  logic w_timer_dec;
  logic w_timer_expired;

  // Ready is a state decode so it drops in the reset cycle and returns right after.
`ifdef ALU_SEQ_OVERLAP_EN
  assign w_ready = !i_reset &&
                   (((r_state == S_IDLE) && !r_err_illegal) || (r_state == S_WRITEBACK));
`else
  assign w_ready = !i_reset && (r_state == S_IDLE) && !r_err_illegal;
`endif

  assign w_accept     = i_op_valid && w_ready;
  assign w_launch     = w_accept && (i_op_src_b <= SRC_B_IMM);
  assign w_drop       = w_accept && (i_op_src_b > SRC_B_IMM);
  assign w_timer_load = (r_state == S_OPERAND);
  assign w_timer_dec  = (r_state == S_EXECUTE);

  alu_latency_timer u_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (w_timer_load),
    .i_value   (LAT_LOAD),
    .i_dec     (w_timer_dec),
    .o_expired (w_timer_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_op            <= '0;
      r_mux_en        <= 1'b0;
      r_alu_start     <= 1'b0;
      r_wb_sel        <= '0;
      r_wb_en         <= 1'b0;
      r_done          <= 1'b0;
      r_err_illegal   <= 1'b0;
      r_ops_completed <= '0;
    end else begin
      r_alu_start   <= 1'b0;
      r_wb_en       <= 1'b0;
      r_done        <= 1'b0;
      r_err_illegal <= 1'b0;

      case (r_state)
        S_IDLE:      r_state <= S_IDLE;
        S_OPERAND:   r_state <= S_EXECUTE;
        S_EXECUTE: begin
          if (w_timer_expired) begin
            r_state         <= S_WRITEBACK;
            r_mux_en        <= 1'b0;
            r_wb_sel        <= r_op.dst;
            r_wb_en         <= r_op.wb;
            r_done          <= 1'b1;
            r_ops_completed <= r_ops_completed + CNT_WIDTH'(1);
          end
        end
        S_WRITEBACK: r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase

      // NOTE: non-blocking assignments take the last one issued in the block, so the
      // handshake below overrides the per-state next state without any ordering hazard.
      if (w_launch) begin
        r_op.src_a  <= i_op_src_a;
        r_op.src_b  <= i_op_src_b;
        r_op.dst    <= i_op_dst;
        r_op.wb     <= i_op_wb;
        if (i_op_src_b == SRC_B_IMM) begin
          r_op.imm <= IMM_W'(i_op_imm);
        end
        r_mux_en    <= 1'b1;
        r_alu_start <= 1'b1;
        r_state     <= S_OPERAND;
      end

      // Illegal side-B source: consume the handshake but leave the datapath untouched.
      if (w_drop) begin
        r_err_illegal <= 1'b1;
        r_state       <= S_IDLE;
      end
    end
  end

  assign o_op_ready      = w_ready;
  assign o_sel_a         = r_op.src_a;
  assign o_sel_b         = r_op.src_b;
  assign o_imm_out       = WORD_SIZE'(r_op.imm);
  assign o_mux_en        = r_mux_en;
  assign o_alu_start     = r_alu_start;
  assign o_wb_sel        = r_wb_sel;
  assign o_wb_en         = r_wb_en;
  assign o_done          = r_done;
  assign o_err_illegal   = r_err_illegal;
  assign o_ops_completed = r_ops_completed;

endmodule
